// File: rtl/cmp3_triple_loader.sv
// rtl/cmp3_triple_loader.sv - serial a/b/c operand loader and result reporter for the 3-bit comparator
// Optional feature macro: CMP3_LOADER_ABORT_EN (adds i_abort, which restarts a partial load)
module cmp3_triple_loader #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
`ifdef CMP3_LOADER_ABORT_EN
  input  logic             i_abort,
`endif
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_in_data,
  output logic [2:0]       o_a,
  output logic [2:0]       o_b,
  output logic [2:0]       o_c,
  input  logic             i_cmp_out,
  output logic             o_res_valid,
  input  logic             i_res_ready,
  output logic             o_res_bit,
  output logic [CNT_W-1:0] o_res_index,
  output logic [CNT_W-1:0] o_hit_count
);

  typedef enum logic [2:0] {
    S_LOAD_A = 3'd0,
    S_LOAD_B = 3'd1,
    S_LOAD_C = 3'd2,
    S_EVAL   = 3'd3,
    S_REPORT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HIT_MAX = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_a;
  logic [2:0]       r_b;
  logic [2:0]       r_c;
  logic             r_res_bit;
  logic [CNT_W-1:0] r_res_index;
  logic [CNT_W-1:0] r_hit_count;

  logic             w_abort;
  logic             w_in_ready;
  logic             w_res_valid;
  logic             w_load_a;
  logic             w_load_b;
  logic             w_load_c;
  logic             w_eval;
  logic             w_res_take;

`ifdef CMP3_LOADER_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  // State register; reset always lands in LOAD_A with nothing pending
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_LOAD_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state, handshake outputs and per-register load strobes
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_res_valid  = 1'b0;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_c     = 1'b0;
    w_eval       = 1'b0;
    w_res_take   = 1'b0;
    case (r_state)
      S_LOAD_A: begin
        // Ready is held low during reset so nothing is taken from upstream then
        w_in_ready = ~i_rst & ~w_abort;
        if (w_abort) begin
          w_state_next = S_LOAD_A;
        end else if (i_in_valid && w_in_ready) begin
          w_load_a     = 1'b1;
          w_state_next = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        w_in_ready = ~i_rst & ~w_abort;
        if (w_abort) begin
          w_state_next = S_LOAD_A;
        end else if (i_in_valid && w_in_ready) begin
          w_load_b     = 1'b1;
          w_state_next = S_LOAD_C;
        end
      end
      S_LOAD_C: begin
        w_in_ready = ~i_rst & ~w_abort;
        if (w_abort) begin
          w_state_next = S_LOAD_A;
        end else if (i_in_valid && w_in_ready) begin
          w_load_c     = 1'b1;
          w_state_next = S_EVAL;
        end
      end
      S_EVAL: begin
        // Operands have been stable for a full cycle; sample the comparator now
        w_eval       = 1'b1;
        w_state_next = S_REPORT;
      end
      S_REPORT: begin
        w_res_valid = 1'b1;
        if (i_res_ready) begin
          w_res_take   = 1'b1;
          w_state_next = S_LOAD_A;
        end
      end
      default: begin
        w_state_next = S_LOAD_A;
      end
    endcase
  end

  // Operand registers only change on their own transfer, never on abort
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a <= 3'd0;
      r_b <= 3'd0;
      r_c <= 3'd0;
    end else begin
      if (w_load_a) r_a <= i_in_data;
      if (w_load_b) r_b <= i_in_data;
      if (w_load_c) r_c <= i_in_data;
    end
  end

  // Capture the comparator result at the end of EVAL; held through REPORT
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res_bit <= 1'b0;
    end else if (w_eval) begin
      r_res_bit <= i_cmp_out;
    end
  end

  // Saturating count of true results; sticks at all-ones instead of wrapping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit_count <= '0;
    end else if (w_eval && i_cmp_out && (r_hit_count != HIT_MAX)) begin
      r_hit_count <= r_hit_count + 1'b1;
    end
  end

  // Result index advances once the consumer takes the result, wrapping naturally
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_res_index <= '0;
    end else if (w_res_take) begin
      r_res_index <= r_res_index + 1'b1;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_res_valid = w_res_valid;
  assign o_a         = r_a;
  assign o_b         = r_b;
  assign o_c         = r_c;
  assign o_res_bit   = r_res_bit;
  assign o_res_index = r_res_index;
  assign o_hit_count = r_hit_count;

endmodule

// File: tb/tb_cmp3_triple_loader.sv
// tb/tb_cmp3_triple_loader.sv - randomized self-checking bench for cmp3_triple_loader
module tb_cmp3_triple_loader;

  localparam int CW   = 2;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_data;
  logic [2:0]    a;
  logic [2:0]    b;
  logic [2:0]    c;
  logic          cmp_out;
  logic          res_valid;
  logic          res_ready;
  logic          res_bit;
  logic [CW-1:0] res_index;
  logic [CW-1:0] hit_count;
  logic          force_one;
`ifdef CMP3_LOADER_ABORT_EN
  logic          abort;
`endif

  int n_total  = 0;
  int n_bad    = 0;
  int exp_idx  = 0;
  int exp_hits = 0;
  int cyc      = 0;

  cmp3_triple_loader #(.CNT_W(CW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
`ifdef CMP3_LOADER_ABORT_EN
    .i_abort     (abort),
`endif
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_a         (a),
    .o_b         (b),
    .o_c         (c),
    .i_cmp_out   (cmp_out),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_bit   (res_bit),
    .o_res_index (res_index),
    .o_hit_count (hit_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference comparator: strictly increasing a < b < c
  function automatic logic cmp_ref(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z);
    return (x < y) && (y < z);
  endfunction

  assign cmp_out = force_one ? 1'b1 : cmp_ref(a, b, c);

  task automatic check_val(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present one operand after `gap` idle cycles; returns just after the transfer edge
  task automatic push_operand(input logic [2:0] d, input int gap);
    logic [2:0] sa, sb, sc;
    int n;
    in_valid = 1'b0;
    sa = a; sb = b; sc = c;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      check_val("gap_in_ready", int'(in_ready), 1);
      check_val("gap_hold", int'({a, b, c}), int'({sa, sb, sc}));
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 20) begin
        check_val("in_ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_triple(input logic [2:0] x, input logic [2:0] y, input logic [2:0] z, input int gmax);
    push_operand(x, (gmax > 0) ? $urandom_range(gmax, 0) : 0);
    push_operand(y, (gmax > 0) ? $urandom_range(gmax, 0) : 0);
    push_operand(z, (gmax > 0) ? $urandom_range(gmax, 0) : 0);
  endtask

  // Called right after c transferred; checks EVAL, REPORT and the return to LOAD_A
  task automatic get_result(input int stall, input logic pre_ready,
                            input logic [2:0] ea, input logic [2:0] eb, input logic [2:0] ec);
    logic exp_bit;
    int   n;
    exp_bit = force_one ? 1'b1 : cmp_ref(ea, eb, ec);
    if (exp_bit) exp_hits = (exp_hits < MAXV) ? exp_hits + 1 : MAXV;
    res_ready = pre_ready;
    in_valid  = 1'b1;
    in_data   = 3'($urandom);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (res_valid) break;
      if (n == 1) begin
        check_val("eval_operands", int'({a, b, c}), int'({ea, eb, ec}));
        check_val("eval_in_ready", int'(in_ready), 0);
      end
      if (n > 20) begin
        check_val("res_valid_timeout", 0, 1);
        break;
      end
    end
    check_val("latency", n, 2);
    check_val("report_operands", int'({a, b, c}), int'({ea, eb, ec}));
    check_val("res_bit", int'(res_bit), int'(exp_bit));
    check_val("res_index", int'(res_index), exp_idx % (MAXV + 1));
    check_val("hit_count", int'(hit_count), exp_hits);
    check_val("report_in_ready", int'(in_ready), 0);
    if (!pre_ready) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check_val("stall_valid", int'(res_valid), 1);
        check_val("stall_in_ready", int'(in_ready), 0);
        check_val("stall_bit", int'(res_bit), int'(exp_bit));
        check_val("stall_index", int'(res_index), exp_idx % (MAXV + 1));
      end
      res_ready = 1'b1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b0;
    exp_idx++;
    check_val("post_res_valid", int'(res_valid), 0);
    check_val("post_in_ready", int'(in_ready), 1);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_abc"}, int'({a, b, c}), 0);
    check_val({tag, "_res_valid"}, int'(res_valid), 0);
    check_val({tag, "_res_bit"}, int'(res_bit), 0);
    check_val({tag, "_res_index"}, int'(res_index), 0);
    check_val({tag, "_hit_count"}, int'(hit_count), 0);
  endtask

  initial begin
    int t1, t2;
    logic [2:0] x, y, z;
    int st;
    logic pr;
    force_one = 1'b0;
`ifdef CMP3_LOADER_ABORT_EN
    abort = 1'b0;
`endif
    // Reset for two cycles with stimulus active
    rst = 1'b1; in_valid = 1'b1; in_data = 3'd5; res_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("rst_in_ready", int'(in_ready), 0);
    check_reset_state("rst");
    rst = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    #1;
    check_val("post_rst_in_ready", int'(in_ready), 1);

    // Back-to-back triples and throughput
    push_triple(3'd0, 3'd3, 3'd5, 0);
    t1 = cyc;
    get_result(0, 1'b1, 3'd0, 3'd3, 3'd5);
    push_triple(3'd1, 3'd7, 3'd5, 0);
    t2 = cyc;
    get_result(0, 1'b1, 3'd1, 3'd7, 3'd5);
    check_val("triple_period", t2 - t1, 5);

    // Source stall before c
    push_operand(3'd2, 0);
    push_operand(3'd1, 0);
    push_operand(3'd5, 3);
    get_result(0, 1'b1, 3'd2, 3'd1, 3'd5);

    // Consumer backpressure
    push_triple(3'd1, 3'd2, 3'd6, 0);
    get_result(4, 1'b0, 3'd1, 3'd2, 3'd6);

    // Reset in the middle of a load discards everything
    push_operand(3'd4, 0);
    push_operand(3'd6, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_state("midrst");
    exp_idx = 0; exp_hits = 0;

    // Saturation and index wrap with a forced-true comparator
    force_one = 1'b1;
    for (int i = 0; i < 5; i++) begin
      x = 3'($urandom); y = 3'($urandom); z = 3'($urandom);
      push_triple(x, y, z, 1);
      get_result(0, 1'b1, x, y, z);
    end
    force_one = 1'b0;

`ifdef CMP3_LOADER_ABORT_EN
    // Abort in LOAD_C restarts the load; operands keep their values
    push_operand(3'd3, 0);
    push_operand(3'd3, 0);
    x = c;
    in_valid = 1'b1; in_data = 3'd7; abort = 1'b1;
    @(negedge clk);
    check_val("abort_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    check_val("abort_c_kept", int'(c), int'(x));
    check_val("abort_in_ready_after", int'(in_ready), 1);
    push_triple(3'd3, 3'd5, 3'd4, 0);
    get_result(0, 1'b1, 3'd3, 3'd5, 3'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("abort_single_result", int'(res_valid), 0);
    end
    @(posedge clk); #1;
`endif

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      force_one = ($urandom_range(7, 0) == 0);
      x = 3'($urandom); y = 3'($urandom); z = 3'($urandom);
      if ($urandom_range(2, 0) == 0) begin
        x = 3'($urandom_range(2, 0)); y = x + 3'($urandom_range(2, 1)); z = y + 3'($urandom_range(2, 1));
      end
      st = $urandom_range(3, 0);
      pr = ($urandom_range(1, 0) == 1);
      push_triple(x, y, z, 2);
      get_result(st, pr, x, y, z);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
